// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 scancode decoder for the pong game: tracks the paddle keys,
// pulses start on space and reports each decoded make/break event.
module ps2_key_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 2_500_000,
    parameter int unsigned TMR_W       = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       p1_up,
    output logic       p1_dn,
    output logic       p2_up,
    output logic       p2_dn,
    output logic       start_tick,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       code_ext,
    output logic       code_brk
);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

    state_t           state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [2:0]       skip_cnt, skip_n;
    logic             accept, expire;
    logic             ev, ev_ext, ev_brk, flush;

    assign rx_en  = enable;
    assign accept = rx_done_tick & enable;
    assign expire = (timer == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_n = state;
        timer_n = timer;
        skip_n  = skip_cnt;
        ev      = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        flush   = 1'b0;
        if (accept) begin
            // an accepted byte always beats a simultaneous timeout
            timer_n = '0;
            unique case (state)
                IDLE: begin
                    unique case (rx_data)
                        8'hE0: state_n = EXT;
                        8'hF0: state_n = BRK;
                        8'hE1: begin
                            state_n = SKIP;
                            skip_n  = 3'd7;
                        end
                        8'h00, 8'hFF:        flush = 1'b1;
                        8'hAA, 8'hFA, 8'hFE: ;
                        default:             ev = 1'b1;
                    endcase
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_n = EXT_BRK;
                    end else if (rx_data != 8'hE0) begin
                        state_n = IDLE;
                        ev      = 1'b1;
                        ev_ext  = 1'b1;
                    end
                end
                BRK: begin
                    state_n = IDLE;
                    ev      = 1'b1;
                    ev_brk  = 1'b1;
                end
                EXT_BRK: begin
                    state_n = IDLE;
                    ev      = 1'b1;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                end
                SKIP: begin
                    skip_n = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_n  = '0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (expire) begin
                state_n = IDLE;
                timer_n = '0;
                skip_n  = '0;
            end else begin
                timer_n = timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            timer    <= '0;
            skip_cnt <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            skip_cnt <= skip_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_up      <= 1'b0;
            p1_dn      <= 1'b0;
            p2_up      <= 1'b0;
            p2_dn      <= 1'b0;
            start_tick <= 1'b0;
            code_valid <= 1'b0;
            code       <= '0;
            code_ext   <= 1'b0;
            code_brk   <= 1'b0;
        end else begin
            code_valid <= ev;
            start_tick <= ev & ~ev_ext & ~ev_brk & (rx_data == 8'h29);
            if (ev) begin
                code     <= rx_data;
                code_ext <= ev_ext;
                code_brk <= ev_brk;
                if (!ev_ext && rx_data == 8'h1D) p1_up <= ~ev_brk;
                if (!ev_ext && rx_data == 8'h1B) p1_dn <= ~ev_brk;
                if (ev_ext && rx_data == 8'h75)  p2_up <= ~ev_brk;
                if (ev_ext && rx_data == 8'h72)  p2_dn <= ~ev_brk;
            end
            if (flush) begin
                p1_up <= 1'b0;
                p1_dn <= 1'b0;
                p2_up <= 1'b0;
                p2_dn <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed scancode sequences followed by random
// byte streams, every cycle compared against a prefix/skip reference model.
module tb_ps2_key_ctrl;

    localparam int unsigned T = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en, p1_up, p1_dn, p2_up, p2_dn, start_tick, code_valid, code_ext, code_brk;
    logic [7:0] code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model: pending prefix flags, bytes left to skip, held keys
    bit       m_ext, m_brk;
    int       m_skip;
    int       m_last;
    bit       m_keys[4];
    bit       m_valid, m_start, m_cext, m_cbrk;
    bit [7:0] m_code;
    int       valid_seen;

    ps2_key_ctrl #(.TIMEOUT_CYC(T), .TMR_W(6)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rx_done_tick(rx_done_tick),
        .rx_data(rx_data), .rx_en(rx_en), .p1_up(p1_up), .p1_dn(p1_dn),
        .p2_up(p2_up), .p2_dn(p2_dn), .start_tick(start_tick),
        .code_valid(code_valid), .code(code), .code_ext(code_ext), .code_brk(code_brk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_skip = 0; m_last = cyc;
        for (int k = 0; k < 4; k++) m_keys[k] = 0;
        m_valid = 0; m_start = 0; m_cext = 0; m_cbrk = 0; m_code = 8'h00;
    endtask

    task automatic emit(input bit [7:0] d, input bit ext, input bit brk);
        m_valid = 1; m_code = d; m_cext = ext; m_cbrk = brk;
        m_start = !ext && !brk && d == 8'h29;
        if (!ext && d == 8'h1D) m_keys[0] = !brk;
        if (!ext && d == 8'h1B) m_keys[1] = !brk;
        if (ext && d == 8'h75)  m_keys[2] = !brk;
        if (ext && d == 8'h72)  m_keys[3] = !brk;
    endtask

    task automatic model_byte(input bit [7:0] d);
        if ((m_ext || m_brk || m_skip > 0) && (cyc - m_last) > int'(T)) begin
            m_ext = 0; m_brk = 0; m_skip = 0;
        end
        m_last = cyc;
        if (m_skip > 0) begin
            m_skip--;
        end else if (!m_ext && !m_brk) begin
            if (d == 8'hE0) m_ext = 1;
            else if (d == 8'hF0) m_brk = 1;
            else if (d == 8'hE1) m_skip = 7;
            else if (d == 8'h00 || d == 8'hFF) begin
                for (int k = 0; k < 4; k++) m_keys[k] = 0;
            end else if (!(d == 8'hAA || d == 8'hFA || d == 8'hFE)) emit(d, 0, 0);
        end else if (!m_brk) begin
            if (d == 8'hF0) m_brk = 1;
            else if (d != 8'hE0) begin emit(d, 1, 0); m_ext = 0; end
        end else begin
            emit(d, m_ext, 1); m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic compare_all();
        chk("rx_en", {7'd0, rx_en}, {7'd0, enable});
        chk("code_valid", {7'd0, code_valid}, {7'd0, m_valid});
        chk("start_tick", {7'd0, start_tick}, {7'd0, m_start});
        chk("p1_up", {7'd0, p1_up}, {7'd0, m_keys[0]});
        chk("p1_dn", {7'd0, p1_dn}, {7'd0, m_keys[1]});
        chk("p2_up", {7'd0, p2_up}, {7'd0, m_keys[2]});
        chk("p2_dn", {7'd0, p2_dn}, {7'd0, m_keys[3]});
        chk("code", code, m_code);
        chk("code_ext", {7'd0, code_ext}, {7'd0, m_cext});
        chk("code_brk", {7'd0, code_brk}, {7'd0, m_cbrk});
    endtask

    // one clock: drive inputs, advance the model at the edge, compare after it
    task automatic cycle(input logic dv, input logic [7:0] d, input logic en);
        rx_done_tick = dv; rx_data = d; enable = en;
        @(posedge clk);
        cyc++;
        m_valid = 0; m_start = 0;
        if (reset && dv && en) model_byte(d);
        if (!reset) model_reset();
        #1;
        compare_all();
        if (code_valid) valid_seen++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 8'h00, enable);
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        cycle(1, d, enable);
        idle(gap);
    endtask

    initial begin
        bit [7:0] pool[14];
        bit [7:0] b;
        int       g;
        pool = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29, 8'hE0, 8'hF0, 8'hE0,
                 8'hF0, 8'hE1, 8'h00, 8'hAA, 8'h14, 8'hFE};
        model_reset();
        valid_seen = 0;
        cycle(0, 8'h00, 1'b0);
        cycle(0, 8'h00, 1'b0);
        reset = 1'b1;
        enable = 1'b1;
        idle(2);

        // W make then release, 10-cycle gaps
        send(8'h1D, 9); send(8'hF0, 9); send(8'h1D, 9);
        chk("two_events", valid_seen[7:0], 8'd2);

        // up-arrow make and extended release
        send(8'hE0, 2); send(8'h75, 3);
        send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 3);

        // E0 abandoned by timeout, then 72 decodes as plain make
        send(8'hE0, T); send(8'h72, 3);
        chk("timeout_code_ext", {7'd0, code_ext}, 8'd0);
        // byte arriving exactly at the expiry cycle still counts as extended
        send(8'hE0, T - 1); send(8'h75, 3);
        chk("boundary_ext", {7'd0, code_ext}, 8'd1);

        // Pause sequence swallowed, then space
        valid_seen = 0;
        send(8'hE1, 1); send(8'h14, 1); send(8'h77, 1); send(8'hE1, 1);
        send(8'hF0, 1); send(8'h14, 1); send(8'hF0, 1); send(8'h77, 1);
        chk("pause_silent", valid_seen[7:0], 8'd0);
        send(8'h29, 3); send(8'h29, 3);

        // overrun flush with p1_up and p2_dn held
        send(8'h1D, 1); send(8'hE0, 1); send(8'h72, 1);
        send(8'h00, 3);

        // asynchronous reset while in EXT
        send(8'h1D, 1); send(8'hE0, 0);
        reset = 1'b0;
        #2;
        chk("async_p1_up", {7'd0, p1_up}, 8'd0);
        chk("async_code", code, 8'h00);
        model_reset();
        idle(2);
        reset = 1'b1;
        idle(1);

        // bytes ignored while disabled
        enable = 1'b0;
        send(8'hF0, 1); send(8'h1B, 1);
        enable = 1'b1;
        send(8'h1B, 3);
        chk("p1_dn_after_enable", {7'd0, p1_dn}, 8'd1);

        // randomized streams
        for (int i = 0; i < 400; i++) begin
            b = pool[$urandom_range(0, 13)];
            if ($urandom_range(0, 9) == 0) b = 8'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            g = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) g = int'(T) - 1 + $urandom_range(0, 3);
            send(b, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
- Sits between the PS/2 receiver (ps2_rx) and the pong game logic.
- Consumes the received byte stream and decodes set-2 make/break/extended prefix sequences with a small FSM.
- Maintains held-state flags for the four paddle keys, emits a one-cycle start pulse on the space key, and drives the receiver's rx_en.
- A prefix timeout and an E1 (Pause) skip counter keep the decoder resynchronised after corrupted or unusual sequences.

Parameters:
- TIMEOUT_CYC, 2_500_000, cycles allowed between a prefix byte (E0/F0/E1) and the next byte before the FSM abandons the sequence. 50 ms at 50 MHz.
- TMR_W, 22, width of the timeout counter. Must satisfy 2^TMR_W > TIMEOUT_CYC.

Ports:
- clk, input, 1, system clock. All logic is on the rising edge.
- reset, input, 1, asynchronous active-low reset. 0 clears all state immediately.
- enable, input, 1, 1 = accept bytes. Drives rx_en directly.
- rx_done_tick, input, 1, one-cycle strobe from ps2_rx. rx_data is valid in the same cycle.
- rx_data, input, 8, received scancode byte.
- rx_en, output, 1, receiver enable. Combinational copy of enable.
- p1_up, output, 1, W (1D) held.
- p1_dn, output, 1, S (1B) held.
- p2_up, output, 1, E0 75 (Up arrow) held.
- p2_dn, output, 1, E0 72 (Down arrow) held.
- start_tick, output, 1, one-cycle pulse on space (29) make.
- code_valid, output, 1, one-cycle pulse when a complete key event is decoded.
- code, output, 8, final byte of the last decoded event.
- code_ext, output, 1, last event carried the E0 prefix.
- code_brk, output, 1, last event was a release.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State = IDLE, timer = 0, skip counter = 0.
  - All key flags, start_tick, code_valid, code_ext and code_brk = 0; code = 8'h00.
- Byte acceptance: a byte is consumed only when rx_done_tick = 1 and enable = 1. Bytes arriving while enable = 0 are ignored and do not change state.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> SKIP with skip counter = 7.
    - 00, FF, AA, FA or FE -> stay in IDLE, no event. 00 and FF (overrun/error) also clear all four key flags.
    - Any other byte -> make event, non-extended; stay in IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT and restart the timer; any other byte -> make event, extended; go to IDLE.
  - BRK: any byte -> break event, non-extended; go to IDLE.
  - EXT_BRK: any byte -> break event, extended; go to IDLE.
  - SKIP: each accepted byte decrements the skip counter; reaching 0 -> IDLE. No events are produced in SKIP.
- Timeout:
  - The timer clears on every accepted byte and counts only in EXT, BRK, EXT_BRK and SKIP.
  - At TIMEOUT_CYC - 1 the FSM returns to IDLE with no event, and the timer and skip counter clear.
  - If an accepted byte and timeout expiry occur in the same cycle, the byte wins and is processed in the current state.
- Event output (registered, one cycle after the rx_done_tick that completes the event):
  - code_valid = 1 for exactly that cycle.
  - code, code_ext and code_brk update and hold until the next event.
- Key flags (update on the same cycle as code_valid):
  - A make event sets the matching flag; a break event clears it.
  - Extended 1D/1B and non-extended 75/72 do not match any flag.
- start_tick: pulses together with code_valid only for a non-extended make of 29. Typematic repeats of 29 pulse again.
- Repeated makes (typematic): flags stay set; code_valid pulses on every repeat.
- enable falling mid-sequence: state and timer continue, so the timeout still recovers the FSM.

Test Plan:
- Reset released, bytes 1D, then F0 1D (10 clk gap between strobes) -> p1_up = 1 one clock after the 1D strobe; p1_up = 0 one clock after the second 1D; two code_valid pulses; second event has code = 1D, code_brk = 1.
- Bytes E0 75, then E0 F0 75 -> p2_up set then cleared; code_ext = 1 on both events; p1_* flags unchanged.
- Byte E0 followed by no strobes for TIMEOUT_CYC cycles, then 72 -> no event from the timeout; the 72 decodes as non-extended make with no p2_dn; code = 72, code_ext = 0.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 29 -> no code_valid during the eight bytes; start_tick = 1 for exactly one cycle after the 29.
- With p1_up and p2_dn held, byte 00 -> both flags clear next cycle, no code_valid. Then reset pulled to 0 mid-EXT -> all outputs 0 immediately, without a clock edge.
- enable = 0, bytes F0 1B -> rx_en = 0, no state change. Then enable = 1, byte 1B -> make event and p1_dn = 1.
